cla_addsub_pipe: RTL and testbench
==================================

Name: cla_addsub_pipe

Overview:
- Two-stage pipelined WIDTH-bit adder/subtractor built from 4-bit carry look-ahead groups.
- Stage 1 computes the low half of the result; stage 2 computes the high half using the registered mid-carry.
- Sits between the operand-issue logic and the ALU result mux.
- Valid/ready handshakes on both sides, with full backpressure and one operation per cycle throughput.

Parameters:
- WIDTH, 32: operand/result width; must be a multiple of 8 (two halves, each a multiple of 4).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operands presented.
- in_ready  out  1  block accepts operands this cycle.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_sub  in  1  1 = A - B, 0 = A + B.
- out_valid  out  1  result presented.
- out_ready  in  1  consumer accepts result this cycle.
- out_sum  out  WIDTH  result bits.
- out_cout  out  1  carry out of MSB (for sub: 1 = no borrow).
- out_ovf  out  1  two's-complement signed overflow.
- out_zero  out  1  out_sum == 0.

Behaviour:
- Reset (async assert, sync-safe deassert by design):
  - s1_valid = 0, s2_valid = 0; all data registers 0.
  - Resulting outputs: in_ready = 1, out_valid = 0, out_sum = 0, out_cout = 0, out_ovf = 0, out_zero = 0.
- Operand conditioning (combinational, before stage 1):
  - B' = in_sub ? ~in_b : in_b; carry-in = in_sub.
  - Per bit: g = a & B', p = a ^ B'.
- Stage 1 (on accept, in_valid & in_ready):
  - Low half = bits [WIDTH/2-1:0] via 4-bit lookahead groups plus second-level group lookahead.
  - Registers: low sum, mid-carry c[WIDTH/2], high-half A and B', sub flag.
  - s1_valid <= 1.
- Stage 2 (when s1 advances):
  - High half from the registered operands with carry-in = registered mid-carry.
  - Registers: full sum; cout = c[WIDTH]; ovf = c[WIDTH] ^ c[WIDTH-1]; zero = ~|sum.
  - s2_valid <= 1.
- Advance rules:
  - s2 may load when !s2_valid | out_ready.
  - s1 advances when s1_valid and s2 may load.
  - in_ready = !s1_valid | (s2 may load). This is combinational from out_ready; no combinational path from in_valid to in_ready.
  - If a stage empties without being refilled in the same cycle, its valid bit clears.
- Latency and throughput:
  - Latency with no stall: accept at cycle N, out_valid at cycle N+2.
  - Throughput is 1 per cycle with out_ready held high.
- Backpressure:
  - out_ready = 0 with both stages full: in_ready = 0.
  - All registers hold; outputs stay stable while out_valid & !out_ready.
- Simultaneous events:
  - Accept and output handoff can occur in the same cycle.
  - Stage 1 refill and stage 1 -> stage 2 transfer can occur in the same cycle.
  - No bubble is inserted in either case.
- Reset mid-operation:
  - In-flight results are discarded.
  - The next cycle after deassert behaves as post-reset empty.
- Arithmetic wrap-around: modulo 2^WIDTH. The flags are the only overflow indication.
- Data register enables: data registers load only on stage advance; they do not toggle when the stage is empty.

Decomposition:
- Shared package alu_pkg: localparam GROUP_W = 4; typedef struct for the stage-1 register (lo_sum, mid_c, hi_a, hi_b, sub); typedef struct for flags (cout, ovf, zero).
- Sub-module cla_adder_half:
  - Combinational N-bit adder built from 4-bit lookahead groups with group g/p and second-level lookahead.
  - Instantiated twice, once per stage.
  - Outputs: sum, cout, and c[N-1] for overflow.

Test Plan:
- Add 0x7FFFFFFF + 0x00000001, out_ready = 1 -> after 2 cycles: sum 0x80000000, cout 0, ovf 1, zero 0.
- Sub 0x00000000 - 0x00000001 -> sum 0xFFFFFFFF, cout 0, ovf 0. Sub 0x00000005 - 0x00000005 -> sum 0, cout 1, zero 1.
- Add 0xFFFFFFFF + 0x00000001 -> sum 0, cout 1, ovf 0, zero 1. Add 0x0000FFFF + 0x00000001 -> sum 0x00010000, which checks the mid-carry crossing.
- 8 back-to-back accepts with out_ready = 1 -> 8 results on consecutive cycles, in order, starting 2 cycles after the first accept. Then 1000 random ops checked against a reference model.
- Hold out_ready = 0 after 3 accepts -> in_ready drops after the 2nd accept; out_sum is stable. Release -> the remaining results drain in order with no loss or duplication.
- Assert rst with both stages full -> out_valid = 0 and in_ready = 1 immediately (async). No stale result appears after deassert.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the pipelined carry look-ahead adder/subtractor:
// lookahead group width, result flag bundle and the overflow helper.
package alu_pkg;

    // Bits covered by one first-level carry look-ahead group.
    localparam int GROUP_W = 4;

    // Status flags produced alongside the result.
    typedef struct packed {
        logic cout;   // carry out of the MSB (subtract: 1 = no borrow)
        logic ovf;    // two's-complement signed overflow
        logic zero;   // result is all zeros
    } flags_t;

    // Signed overflow occurs when the carry into the MSB differs from the
    // carry out of it.
    function automatic logic signed_ovf(input logic c_out, input logic c_into_msb);
        return c_out ^ c_into_msb;
    endfunction

endpackage

// File: rtl/cla_adder_half.sv
// Combinational N-bit adder built from 4-bit carry look-ahead groups.
// Group generate/propagate terms feed a second-level lookahead that produces
// every group carry-in directly from the operands and cin.
module cla_adder_half
    import alu_pkg::*;
#(
    parameter int N = 16
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout,
    output logic         c_msb
);

    localparam int NG = N / GROUP_W;

    logic [N-1:0]  g;
    logic [N-1:0]  p;
    logic [NG-1:0] grp_g;
    logic [NG-1:0] grp_p;
    logic [NG:0]   grp_c;
    logic [N:0]    c;

    assign g = a & b;
    assign p = a ^ b;

    // Two-level lookahead: group G/P, group carries, then per-bit carries.
    always_comb begin : lookahead
        logic t;
        logic pp;
        t     = 1'b0;
        pp    = 1'b1;
        grp_g = '0;
        grp_p = '0;
        grp_c = '0;
        c     = '0;

        // Group generate/propagate: G = g3 | p3 g2 | p3 p2 g1 | p3 p2 p1 g0
        for (int k = 0; k < NG; k++) begin
            t  = 1'b0;
            pp = 1'b1;
            for (int j = GROUP_W - 1; j >= 0; j--) begin
                t  = t | (pp & g[k*GROUP_W + j]);
                pp = pp & p[k*GROUP_W + j];
            end
            grp_g[k] = t;
            grp_p[k] = pp;
        end

        // Second level: each group carry-in expanded over all lower groups.
        grp_c[0] = cin;
        for (int k = 0; k < NG; k++) begin
            t  = 1'b0;
            pp = 1'b1;
            for (int j = k; j >= 0; j--) begin
                t  = t | (pp & grp_g[j]);
                pp = pp & grp_p[j];
            end
            grp_c[k+1] = t | (pp & cin);
        end

        // Bit carries inside each group, looked ahead from the group carry-in.
        for (int k = 0; k < NG; k++) begin
            for (int i = 0; i < GROUP_W; i++) begin
                t  = 1'b0;
                pp = 1'b1;
                for (int j = i - 1; j >= 0; j--) begin
                    t  = t | (pp & g[k*GROUP_W + j]);
                    pp = pp & p[k*GROUP_W + j];
                end
                c[k*GROUP_W + i] = t | (pp & grp_c[k]);
            end
        end
        c[N] = grp_c[NG];
    end

    assign sum   = p ^ c[N-1:0];
    assign cout  = c[N];
    assign c_msb = c[N-1];

endmodule

// File: rtl/cla_addsub_pipe.sv
// Two-stage pipelined adder/subtractor. Stage 1 adds the low half and
// registers the mid carry with the high-half operands; stage 2 adds the high
// half and registers the full result with its flags. Valid/ready on both
// sides with full backpressure and one operation per cycle.
// WIDTH must be a multiple of 8 so each half is a whole number of groups.
module cla_addsub_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_zero
);

    localparam int HALF = WIDTH / 2;

    // Stage-1 register contents; width-dependent, so declared locally.
    typedef struct packed {
        logic [HALF-1:0] lo_sum;
        logic            mid_c;
        logic [HALF-1:0] hi_a;
        logic [HALF-1:0] hi_b;
    } stage1_t;

    function automatic logic all_zero(input logic [WIDTH-1:0] v);
        return ~|v;
    endfunction

    logic [WIDTH-1:0] b_cond;
    logic [HALF-1:0]  lo_sum;
    logic             lo_cout;
    logic             lo_cmsb_unused;
    logic [HALF-1:0]  hi_sum;
    logic             hi_cout;
    logic             hi_cmsb;

    logic             vld_p1;
    logic             vld_p2;
    stage1_t          s1_p1;
    logic [WIDTH-1:0] sum_p2;
    flags_t           flg_p2;

    logic             s2_load;
    logic             s1_adv;
    logic             accept;

    // Operand conditioning: subtraction is A + ~B + 1.
    assign b_cond = in_sub ? ~in_b : in_b;

    // Handshake control; in_ready depends only on state and out_ready.
    assign s2_load  = !vld_p2 || out_ready;
    assign s1_adv   = vld_p1 && s2_load;
    assign in_ready = !vld_p1 || s2_load;
    assign accept   = in_valid && in_ready;

    cla_adder_half #(.N(HALF)) u_lo (
        .a     (in_a[HALF-1:0]),
        .b     (b_cond[HALF-1:0]),
        .cin   (in_sub),
        .sum   (lo_sum),
        .cout  (lo_cout),
        .c_msb (lo_cmsb_unused)
    );

    // ---- stage 1 -> stage 2 boundary ----

    cla_adder_half #(.N(HALF)) u_hi (
        .a     (s1_p1.hi_a),
        .b     (s1_p1.hi_b),
        .cin   (s1_p1.mid_c),
        .sum   (hi_sum),
        .cout  (hi_cout),
        .c_msb (hi_cmsb)
    );

    // Stage valid bits: set on fill, cleared when the stage drains unrefilled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else begin
            vld_p1 <= accept || (vld_p1 && !s1_adv);
            vld_p2 <= s1_adv || (vld_p2 && !out_ready);
        end
    end

    // Stage-1 data: low-half sum, mid carry and high-half operands on accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_p1 <= '0;
        end else if (accept) begin
            s1_p1.lo_sum <= lo_sum;
            s1_p1.mid_c  <= lo_cout;
            s1_p1.hi_a   <= in_a[WIDTH-1:HALF];
            s1_p1.hi_b   <= b_cond[WIDTH-1:HALF];
        end
    end

    // Stage-2 data: full result and flags when stage 1 hands over.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_p2 <= '0;
            flg_p2 <= '0;
        end else if (s1_adv) begin
            sum_p2      <= {hi_sum, s1_p1.lo_sum};
            flg_p2.cout <= hi_cout;
            flg_p2.ovf  <= signed_ovf(hi_cout, hi_cmsb);
            flg_p2.zero <= all_zero({hi_sum, s1_p1.lo_sum});
        end
    end

    assign out_valid = vld_p2;
    assign out_sum   = sum_p2;
    assign out_cout  = flg_p2.cout;
    assign out_ovf   = flg_p2.ovf;
    assign out_zero  = flg_p2.zero;

endmodule

// File: tb/tb_cla_addsub_pipe.sv
// Scoreboard bench for cla_addsub_pipe: the driver pushes expected results as
// operands are accepted, a monitor pops and compares on every output handoff.
module tb_cla_addsub_pipe;

    localparam int W = 32;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        logic         zero;
        int           lat;   // expected output cycle, -1 when not checked
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_cout;
    logic         out_ovf;
    logic         out_zero;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t sb[$];
    bit   tog_run;

    cla_addsub_pipe #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_sub    (in_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf),
        .out_zero  (out_zero)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Independent reference: wide add, signed overflow from operand/result signs.
    function automatic exp_t ref_model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
        exp_t        e;
        logic [W:0]  t;
        logic [W-1:0] bb;
        bb     = sub ? ~b : b;
        t      = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, sub};
        e.sum  = t[W-1:0];
        e.cout = t[W];
        if (sub) e.ovf = (a[W-1] != b[W-1]) && (t[W-1] != a[W-1]);
        else     e.ovf = (a[W-1] == b[W-1]) && (t[W-1] != a[W-1]);
        e.zero = (t[W-1:0] == '0);
        e.lat  = -1;
        return e;
    endfunction

    // Present one operation starting at a falling edge; returns one falling
    // edge after the accepting rising edge.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                         input logic [W-1:0] es, input logic ec, input logic ev,
                         input logic ez, input bit lat);
        int   n;
        exp_t e;
        n = 0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_sub   = sub;
        #1;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles, required 1", n);
        end else begin
            e.sum  = es;
            e.cout = ec;
            e.ovf  = ev;
            e.zero = ez;
            e.lat  = lat ? cyc + 2 : -1;
            sb.push_back(e);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic issue_rand(input bit lat);
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         s;
        exp_t         m;
        a = $urandom;
        b = $urandom;
        s = 1'($urandom_range(0, 1));
        m = ref_model(a, b, s);
        issue(a, b, s, m.sum, m.cout, m.ovf, m.zero, lat);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", sb.size(), 0);
    endtask

    // Monitor: compare each result at the cycle it is handed to the consumer.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (!rst && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got sum %0h, required no output", out_sum);
                end else begin
                    e = sb.pop_front();
                    chk("result", {out_sum, out_cout, out_ovf, out_zero},
                        {e.sum, e.cout, e.ovf, e.zero});
                    if (e.lat >= 0) chk("latency_cycle", cyc, e.lat);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_sub    = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_sum", out_sum, 0);
        chk("rst_out_cout", out_cout, 0);
        chk("rst_out_ovf", out_ovf, 0);
        chk("rst_out_zero", out_zero, 0);
        @(negedge clk);
        rst       = 1'b0;
        out_ready = 1'b1;

        // Directed edge cases, latency checked.
        issue(32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0, 1);
        issue(32'h00000000, 32'h00000001, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1);
        issue(32'h00000005, 32'h00000005, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1, 1);
        issue(32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1, 1);
        issue(32'h0000FFFF, 32'h00000001, 1'b0, 32'h00010000, 1'b0, 1'b0, 1'b0, 1);
        drain();

        // Eight back-to-back accepts: results on consecutive cycles, in order.
        issue(32'h00000001, 32'h00000002, 1'b0, 32'h00000003, 1'b0, 1'b0, 1'b0, 1);
        issue(32'h0000000A, 32'h00000003, 1'b1, 32'h00000007, 1'b1, 1'b0, 1'b0, 1);
        issue(32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b1, 1);
        issue(32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0, 1);
        issue(32'h12345678, 32'h87654321, 1'b0, 32'h99999999, 1'b0, 1'b0, 1'b0, 1);
        issue(32'h00000003, 32'h0000000A, 1'b1, 32'hFFFFFFF9, 1'b0, 1'b0, 1'b0, 1);
        issue(32'hFFFF0000, 32'h0000FFFF, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1);
        issue(32'h00008000, 32'h00008000, 1'b0, 32'h00010000, 1'b0, 1'b0, 1'b0, 1);
        drain();

        // Backpressure: two accepts fill the pipe, the third must wait.
        out_ready = 1'b0;
        issue(32'h00000100, 32'h00000200, 1'b0, 32'h00000300, 1'b0, 1'b0, 1'b0, 0);
        issue(32'h00000050, 32'h00000020, 1'b1, 32'h00000030, 1'b1, 1'b0, 1'b0, 0);
        fork
            issue(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFE, 1'b1, 1'b0, 1'b0, 0);
            begin
                #1;
                chk("bp_in_ready_low", in_ready, 0);
                repeat (3) begin
                    @(negedge clk);
                    #1;
                    chk("bp_in_ready_low", in_ready, 0);
                    chk("bp_out_valid", out_valid, 1);
                    chk("bp_out_sum_stable", out_sum, 32'h00000300);
                end
                @(negedge clk);
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset with both stages full: immediate clear, nothing stale after.
        out_ready = 1'b0;
        issue(32'h11111111, 32'h22222222, 1'b0, 32'h33333333, 1'b0, 1'b0, 1'b0, 0);
        issue(32'h44444444, 32'h11111111, 1'b1, 32'h33333333, 1'b1, 1'b0, 1'b0, 0);
        sb.delete();
        #3;
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 1);
        @(negedge clk);
        rst       = 1'b0;
        out_ready = 1'b1;
        repeat (4) begin
            @(negedge clk);
            #1;
            chk("postrst_no_stale", out_valid, 0);
        end
        @(negedge clk);

        // Random operations, no stalls, latency checked.
        for (int i = 0; i < 700; i++) issue_rand(1);
        drain();

        // Random operations under random consumer backpressure.
        tog_run = 1'b1;
        fork
            begin
                for (int i = 0; i < 300; i++) issue_rand(0);
                tog_run = 1'b0;
            end
            begin
                while (tog_run) begin
                    @(negedge clk);
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready = 1'b1;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
